level_meter: RTL and testbench

Parametrised windowed peak/gain meter for the channel-strip output stage. Tracks absolute peaks of the input and output waves over a fixed sample window, then computes either the scaled out/in gain ratio or a raw peak, depending on mode. The result is converted to packed BCD for the seven-segment display drivers. A sequential divider and a sequential binary-to-BCD converter keep the block small and let accumulation of the next window continue during conversion.

---
 rtl/level_meter_if.sv | 33 +++
 rtl/level_meter.sv | 222 ++++++++++++++++++++++
 tb/tb_level_meter.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/level_meter_if.sv
// ----------------------------------------------------------------------------
// level_meter_if : sample/result bundle between the channel strip and meter.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface level_meter_if #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 4
) ();
    logic                    sample_en;
    logic [WIDTH-1:0]        in_wave;
    logic [WIDTH-1:0]        out_wave;
    logic [1:0]              mode;
    logic [4*DIGITS-1:0]     bcd;
    logic                    update;
    logic                    busy;
    logic                    overflow;
    logic                    div_zero;
    logic                    clip;

    modport master (
        output sample_en, in_wave, out_wave, mode,
        input  bcd, update, busy, overflow, div_zero, clip
    );

    modport slave (
        input  sample_en, in_wave, out_wave, mode,
        output bcd, update, busy, overflow, div_zero, clip
    );
endinterface

`default_nettype wire

// File: rtl/level_meter.sv
// ----------------------------------------------------------------------------
// level_meter : windowed peak / gain-ratio meter with sequential divide and
//               binary-to-BCD conversion.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module level_meter #(
    parameter int WIDTH  = 16,
    parameter int WINDOW = 12000,
    parameter int SCALE  = 1000,
    parameter int DIGITS = 4
) (
    input  wire logic     clk_48,
    input  wire logic     reset_n,
    level_meter_if.slave  bus
);

    localparam int               c_CW     = $clog2(WINDOW);
    localparam int               c_BW     = 4 * DIGITS;
    localparam logic [c_CW-1:0]  c_LAST   = c_CW'(WINDOW - 1);
    localparam logic [WIDTH-1:0] c_POS_FS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] c_NEG_FS = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [31:0]      c_SCALE  = 32'(SCALE);

    function automatic logic [31:0] f_max_val(input int d);
        logic [31:0] v;
        v = 32'd1;
        for (int i = 0; i < d; i++) v = v * 32'd10;
        return v - 32'd1;
    endfunction

    localparam logic [31:0] c_MAX = f_max_val(DIGITS);

    function automatic logic [WIDTH-1:0] f_mag(input logic [WIDTH-1:0] x);
        if (x == c_NEG_FS)   return c_POS_FS;
        else if (x[WIDTH-1]) return -x;
        else                 return x;
    endfunction

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_BCD  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Window accumulation
    logic [c_CW-1:0]  r_count;
    logic [WIDTH-1:0] r_in_pk;
    logic [WIDTH-1:0] r_out_pk;
    logic             r_clip_acc;

    // Compute pipeline
    state_t           r_state;
    logic [4:0]       r_step;
    logic [31:0]      r_dq;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_rem;
    logic             r_ratio;
    logic             r_dz;
    logic             r_ovf_p;
    logic             r_clip_p;
    logic [c_BW-1:0]  r_acc;

    // Registered outputs
    logic [c_BW-1:0]  r_bcd;
    logic             r_update;
    logic             r_busy;
    logic             r_overflow;
    logic             r_div_zero;
    logic             r_clip;

    logic [WIDTH-1:0] w_in_mag;
    logic [WIDTH-1:0] w_out_mag;
    logic [WIDTH-1:0] w_in_pk_nxt;
    logic [WIDTH-1:0] w_out_pk_nxt;
    logic             w_clip_nxt;
    logic             w_snap;
    logic             w_ratio_in;
    logic [31:0]      w_dividend;
    logic [31:0]      w_load;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH:0]   w_diff;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [31:0]      w_dq_step;
    logic [31:0]      w_val;
    logic             w_over;
    logic [31:0]      w_clamped;
    logic [c_BW-1:0]  w_adj;
    logic             w_unused_bits;

    assign w_in_mag     = f_mag(bus.in_wave);
    assign w_out_mag    = f_mag(bus.out_wave);
    assign w_in_pk_nxt  = (w_in_mag  > r_in_pk)  ? w_in_mag  : r_in_pk;
    assign w_out_pk_nxt = (w_out_mag > r_out_pk) ? w_out_mag : r_out_pk;
    assign w_clip_nxt   = r_clip_acc || (bus.out_wave == c_POS_FS) || (bus.out_wave == c_NEG_FS);
    assign w_snap       = bus.sample_en && (r_count == c_LAST);
    assign w_ratio_in   = (bus.mode == 2'd0) || (bus.mode == 2'd3);

    assign w_dividend   = 32'(w_out_pk_nxt) * c_SCALE;
    assign w_load       = w_ratio_in          ? w_dividend         :
                          (bus.mode == 2'd1)  ? 32'(w_in_pk_nxt)   : 32'(w_out_pk_nxt);

    // One restoring-divide step; peak modes rotate so 32 steps restore the value
    assign w_rem_sh   = {r_rem, r_dq[31]};
    assign w_diff     = w_rem_sh - {1'b0, r_div};
    assign w_ge       = r_ratio && (w_rem_sh >= {1'b0, r_div});
    assign w_rem_nxt  = w_ge ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
    assign w_dq_step  = r_ratio ? {r_dq[30:0], w_ge} : {r_dq[30:0], r_dq[31]};

    assign w_val      = r_dz ? 32'd0 : w_dq_step;
    assign w_over     = (w_val > c_MAX);
    assign w_clamped  = w_over ? c_MAX : w_val;

    genvar d;
    generate
        for (d = 0; d < DIGITS; d++) begin : g_dabble
            assign w_adj[4*d +: 4] = (r_acc[4*d +: 4] >= 4'd5) ? (r_acc[4*d +: 4] + 4'd3)
                                                                : r_acc[4*d +: 4];
        end
    endgenerate

    assign w_unused_bits = w_adj[c_BW-1] ^ w_diff[WIDTH];

    always_ff @(posedge clk_48 or negedge reset_n) begin
        if (!reset_n) begin
            r_count    <= '0;
            r_in_pk    <= '0;
            r_out_pk   <= '0;
            r_clip_acc <= 1'b0;
        end else if (bus.sample_en) begin
            if (w_snap) begin
                r_count    <= '0;
                r_in_pk    <= '0;
                r_out_pk   <= '0;
                r_clip_acc <= 1'b0;
            end else begin
                r_count    <= r_count + c_CW'(1);
                r_in_pk    <= w_in_pk_nxt;
                r_out_pk   <= w_out_pk_nxt;
                r_clip_acc <= w_clip_nxt;
            end
        end
    end

    always_ff @(posedge clk_48 or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_step     <= '0;
            r_dq       <= '0;
            r_div      <= '0;
            r_rem      <= '0;
            r_ratio    <= 1'b0;
            r_dz       <= 1'b0;
            r_ovf_p    <= 1'b0;
            r_clip_p   <= 1'b0;
            r_acc      <= '0;
            r_bcd      <= '0;
            r_update   <= 1'b0;
            r_busy     <= 1'b0;
            r_overflow <= 1'b0;
            r_div_zero <= 1'b0;
            r_clip     <= 1'b0;
        end else begin
            r_update <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_snap) begin
                        r_state  <= S_DIV;
                        r_busy   <= 1'b1;
                        r_step   <= '0;
                        r_rem    <= '0;
                        r_div    <= w_in_pk_nxt;
                        r_ratio  <= w_ratio_in;
                        r_dz     <= w_ratio_in && (w_in_pk_nxt == '0);
                        r_clip_p <= w_clip_nxt;
                        r_dq     <= w_load;
                    end
                end
                S_DIV: begin
                    r_rem  <= w_rem_nxt;
                    r_step <= r_step + 5'd1;
                    if (r_step == 5'd31) begin
                        r_state <= S_BCD;
                        r_dq    <= w_clamped;
                        r_ovf_p <= w_over;
                        r_acc   <= '0;
                    end else begin
                        r_dq    <= w_dq_step;
                    end
                end
                S_BCD: begin
                    r_acc  <= {w_adj[c_BW-2:0], r_dq[31]};
                    r_dq   <= {r_dq[30:0], 1'b0};
                    r_step <= r_step + 5'd1;
                    if (r_step == 5'd31) r_state <= S_DONE;
                end
                S_DONE: begin
                    r_bcd      <= r_acc;
                    r_overflow <= r_ovf_p;
                    r_div_zero <= r_dz;
                    r_clip     <= r_clip_p;
                    r_update   <= 1'b1;
                    r_busy     <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.bcd      = r_bcd;
    assign bus.update   = r_update;
    assign bus.busy     = r_busy;
    assign bus.overflow = r_overflow;
    assign bus.div_zero = r_div_zero;
    assign bus.clip     = r_clip;

endmodule

`default_nettype wire

// File: tb/tb_level_meter.sv
// ----------------------------------------------------------------------------
// tb_level_meter : scoreboard bench for level_meter (WINDOW = 100).
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_level_meter;

    localparam int c_WIN = 100;

    logic clk_48;
    logic reset_n;
    int   cyc;
    int   n_checks;
    int   n_errors;
    logic r_last_upd;

    typedef struct {
        logic [15:0] bcd;
        logic        ovf;
        logic        dz;
        logic        clip;
        int          t;
    } exp_t;

    exp_t q_exp[$];

    level_meter_if #(.WIDTH(16), .DIGITS(4)) bus ();

    level_meter #(
        .WIDTH (16),
        .WINDOW(c_WIN),
        .SCALE (1000),
        .DIGITS(4)
    ) dut (
        .clk_48 (clk_48),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial clk_48 = 1'b0;
    always #5 clk_48 = ~clk_48;

    always @(posedge clk_48) cyc = cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    function automatic int f_mag(input logic signed [15:0] x);
        int a;
        a = x;
        if (a < 0) a = -a;
        if (a > 32767) a = 32767;
        return a;
    endfunction

    function automatic logic [15:0] f_bcd(input int v);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic signed [15:0] f_below(input int mag);
        int v;
        if (mag <= 1) return 16'sd0;
        v = int'($urandom_range(mag - 1, 0));
        if ($urandom_range(1, 0) == 1) v = -v;
        return 16'(v);
    endfunction

    task automatic drive(input logic en, input logic [15:0] iw, input logic [15:0] ow,
                         input logic [1:0] m);
        @(posedge clk_48);
        #1;
        bus.sample_en = en;
        bus.in_wave   = iw;
        bus.out_wave  = ow;
        bus.mode      = m;
    endtask

    // One full window; the expected result is queued when the closing sample is driven
    task automatic run_window(input int m, input int in_sp, input int out_sp, input bit sparse);
        int ipk, opk, val;
        bit clp;
        logic signed [15:0] iw, ow;
        logic [1:0] md;
        exp_t e;
        ipk = 0; opk = 0; clp = 0;
        for (int k = 0; k < c_WIN; k++) begin
            if (sparse) drive(1'b0, 16'h7fff, 16'h8000, 2'($urandom));
            iw = (k == 37) ? 16'(in_sp)  : f_below(f_mag(16'(in_sp)));
            ow = (k == 37) ? 16'(out_sp) : f_below(f_mag(16'(out_sp)));
            md = (k == c_WIN - 1) ? 2'(m) : 2'($urandom);
            drive(1'b1, iw, ow, md);
            if (f_mag(iw) > ipk) ipk = f_mag(iw);
            if (f_mag(ow) > opk) opk = f_mag(ow);
            if (ow == 16'sh7fff || ow == -16'sh8000) clp = 1;
        end
        e.dz = 0;
        if (m == 1)      val = ipk;
        else if (m == 2) val = opk;
        else if (ipk == 0) begin
            val  = 0;
            e.dz = 1;
        end else val = (opk * 1000) / ipk;
        e.ovf  = (val > 9999);
        if (e.ovf) val = 9999;
        e.bcd  = f_bcd(val);
        e.clip = clp;
        e.t    = cyc + 66;
        q_exp.push_back(e);
    endtask

    always @(negedge clk_48) begin
        if (reset_n) begin
            if (r_last_upd) chk("upd_pulse", {31'd0, bus.update}, 32'd0);
            if (q_exp.size() > 0 && cyc == q_exp[0].t - 30)
                chk("busy", {31'd0, bus.busy}, 32'd1);
            if (bus.update) begin
                if (q_exp.size() == 0) begin
                    chk("unexp_update", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = q_exp.pop_front();
                    chk("bcd",      {16'd0, bus.bcd},       {16'd0, e.bcd});
                    chk("overflow", {31'd0, bus.overflow},  {31'd0, e.ovf});
                    chk("div_zero", {31'd0, bus.div_zero},  {31'd0, e.dz});
                    chk("clip",     {31'd0, bus.clip},      {31'd0, e.clip});
                    chk("latency",  32'(cyc),               32'(e.t));
                end
            end
        end
        r_last_upd = bus.update;
    end

    initial begin
        int t_snap;
        cyc = 0; n_checks = 0; n_errors = 0; r_last_upd = 1'b0;
        reset_n       = 1'b0;
        bus.sample_en = 1'b0;
        bus.in_wave   = '0;
        bus.out_wave  = '0;
        bus.mode      = 2'd0;
        repeat (5) @(posedge clk_48);
        @(negedge clk_48);
        chk("rst_bcd",  {16'd0, bus.bcd},      32'd0);
        chk("rst_upd",  {31'd0, bus.update},   32'd0);
        chk("rst_busy", {31'd0, bus.busy},     32'd0);
        chk("rst_ovf",  {31'd0, bus.overflow}, 32'd0);
        chk("rst_dz",   {31'd0, bus.div_zero}, 32'd0);
        chk("rst_clip", {31'd0, bus.clip},     32'd0);
        reset_n = 1'b1;

        run_window(0, 16000, 8000, 0);
        run_window(0, 100, -20000, 0);
        run_window(0, 0, 5000, 0);
        run_window(1, -1234, 900, 0);
        run_window(2, 3000, -32768, 0);
        run_window(2, 20000, 300, 1);
        run_window(3, 3000, 4500, 0);

        // Abort in the middle of the divide
        run_window(0, 2000, 3000, 0);
        t_snap = cyc + 1;
        drive(1'b0, '0, '0, 2'd0);
        for (int i = 0; i < 200 && cyc < t_snap + 30; i++) @(posedge clk_48);
        #3;
        reset_n = 1'b0;
        #1;
        chk("abort_bcd",  {16'd0, bus.bcd},      32'd0);
        chk("abort_busy", {31'd0, bus.busy},     32'd0);
        chk("abort_ovf",  {31'd0, bus.overflow}, 32'd0);
        chk("abort_dz",   {31'd0, bus.div_zero}, 32'd0);
        chk("abort_clip", {31'd0, bus.clip},     32'd0);
        void'(q_exp.pop_back());
        repeat (20) @(posedge clk_48);
        @(negedge clk_48);
        reset_n = 1'b1;
        repeat (80) @(posedge clk_48);
        run_window(0, 2000, 3000, 0);

        drive(1'b0, '0, '0, 2'd0);
        for (int i = 0; i < 200 && q_exp.size() > 0; i++) @(posedge clk_48);
        repeat (3) @(posedge clk_48);
        chk("drain", 32'(q_exp.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
